// File: rtl/fir_filter_param_pkg.sv
// Shared types and helpers for the parametrised FIR filter: FSM state
// encoding, accumulator width calculation and the saturating magnitude.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        MAC,
        OUT
    } fir_state_t;

    // Widest scaled result the saturation helper accepts; callers sign-extend into it.
    localparam int SAT_MAX_W = 128;

    typedef struct packed {
        logic                 overflow;
        logic [SAT_MAX_W-1:0] magnitude;
    } sat_result_t;

    // Full-precision accumulator: product width plus headroom for TAPS additions.
    function automatic int acc_width(input int data_w, input int taps);
        return 2 * data_w + $clog2(taps);
    endfunction

    // Magnitude of a signed value, clamped to 2^data_w-1, with an overflow flag.
    function automatic sat_result_t sat_magnitude(input logic signed [SAT_MAX_W-1:0] r,
                                                  input int data_w);
        sat_result_t          res;
        logic [SAT_MAX_W-1:0] one;
        logic [SAT_MAX_W-1:0] limit;
        logic [SAT_MAX_W-1:0] mag;
        one           = {{(SAT_MAX_W-1){1'b0}}, 1'b1};
        limit         = (one << data_w) - one;
        mag           = r[SAT_MAX_W-1] ? unsigned'(-r) : unsigned'(r);
        res.overflow  = (mag > limit);
        res.magnitude = res.overflow ? limit : mag;
        return res;
    endfunction

endpackage

// File: rtl/fir_filter_param_if.sv
// Sample/coefficient request and result bus between the sample source,
// the FIR filter and the magnitude consumer.
interface fir_filter_param_if #(
    parameter int DATA_W = 16
);
    logic signed [DATA_W-1:0] sample_data;
    logic signed [DATA_W-1:0] fir_coefficient;
    logic                     data_ready;
    logic                     load_coeff;
    logic                     modwait;
    logic        [DATA_W-1:0] fir_out;
    logic                     one_k_samples;
    logic                     err;

    modport master (
        output sample_data, fir_coefficient, data_ready, load_coeff,
        input  modwait, fir_out, one_k_samples, err
    );

    modport slave (
        input  sample_data, fir_coefficient, data_ready, load_coeff,
        output modwait, fir_out, one_k_samples, err
    );
endinterface

// File: rtl/fir_sample_counter.sv
// Counts completed samples and emits a one-cycle pulse on every
// SAMPLE_COUNT-th one, aligned with the result register update.
module fir_sample_counter #(
    parameter int SAMPLE_COUNT = 1000
) (
    input  logic clk,
    input  logic n_reset,
    input  logic cnt_up,
    input  logic clear,
    output logic one_k_samples
);
    localparam int CNT_W = $clog2(SAMPLE_COUNT);

    logic [CNT_W-1:0] count;

    // Count completed samples, wrapping and pulsing at the block boundary.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            count         <= '0;
            one_k_samples <= 1'b0;
        end else if (clear) begin
            count         <= '0;
            one_k_samples <= 1'b0;
        end else if (cnt_up) begin
            if (count == CNT_W'(SAMPLE_COUNT - 1)) begin
                count         <= '0;
                one_k_samples <= 1'b1;
            end else begin
                count         <= count + 1'b1;
                one_k_samples <= 1'b0;
            end
        end else begin
            one_k_samples <= 1'b0;
        end
    end
endmodule

// File: rtl/fir_filter_param.sv
// Sequential multiply-accumulate FIR filter: one MAC per tap for each
// accepted sample, serially loaded coefficients, saturated magnitude output.
module fir_filter_param
    import fir_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int TAPS         = 4,
    parameter int SAMPLE_COUNT = 1000
) (
    input logic               clk,
    input logic               n_reset,
    fir_filter_param_if.slave bus
);
    localparam int ACC_W = acc_width(DATA_W, TAPS);
    localparam int TAP_W = $clog2(TAPS);

    fir_state_t               state;
    logic [TAP_W-1:0]         tap_idx;
    logic [TAP_W-1:0]         load_idx;
    logic signed [DATA_W-1:0] x     [TAPS];
    logic signed [DATA_W-1:0] coeff [TAPS];
    logic signed [ACC_W-1:0]  acc;
    logic signed [2*DATA_W-1:0] product;
    logic signed [ACC_W-1:0]  r_val;
    sat_result_t              sat;
    logic                     unused_sat_bits;
    logic                     modwait_q;
    logic [DATA_W-1:0]        fir_out_q;
    logic                     err_q;
    logic                     accept_sample;
    logic                     overrun;
    logic                     coeff_clear;
    logic                     cnt_up;

    assign accept_sample = (state == IDLE) && bus.data_ready;
    assign overrun       = (state != IDLE) && bus.data_ready;
    assign coeff_clear   = (state == LOAD) && (load_idx == '0);
    assign cnt_up        = (state == OUT);

    assign product = (2*DATA_W)'(x[tap_idx]) * (2*DATA_W)'(coeff[tap_idx]);
    assign r_val   = acc >>> (DATA_W - 1);

    // Scale the accumulator back to sample range and clamp its magnitude.
    always_comb begin
        sat = sat_magnitude(SAT_MAX_W'(r_val), DATA_W);
    end

    assign unused_sat_bits = ^sat.magnitude[SAT_MAX_W-1:DATA_W];

    // Request arbitration, MAC sequencing and the registered outputs.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state     <= IDLE;
            modwait_q <= 1'b0;
            fir_out_q <= '0;
            err_q     <= 1'b0;
            tap_idx   <= '0;
            load_idx  <= '0;
            acc       <= '0;
        end else begin
            if (overrun || ((state == OUT) && sat.overflow)) begin
                err_q <= 1'b1;
            end else if (coeff_clear) begin
                err_q <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (bus.data_ready) begin
                        state     <= MAC;
                        modwait_q <= 1'b1;
                        acc       <= '0;
                        tap_idx   <= '0;
                    end else if (bus.load_coeff) begin
                        state     <= LOAD;
                        modwait_q <= 1'b1;
                    end
                end
                LOAD: begin
                    load_idx  <= (load_idx == TAP_W'(TAPS - 1)) ? '0 : load_idx + 1'b1;
                    state     <= IDLE;
                    modwait_q <= 1'b0;
                end
                MAC: begin
                    acc <= acc + ACC_W'(product);
                    if (tap_idx == TAP_W'(TAPS - 1)) begin
                        state <= OUT;
                    end else begin
                        tap_idx <= tap_idx + 1'b1;
                    end
                end
                OUT: begin
                    fir_out_q <= sat.magnitude[DATA_W-1:0];
                    state     <= IDLE;
                    modwait_q <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    modwait_q <= 1'b0;
                end
            endcase
        end
    end

    // Delay line shifts on each accepted sample; coefficients written from LOAD.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < TAPS; i++) begin
                x[i]     <= '0;
                coeff[i] <= '0;
            end
        end else begin
            if (accept_sample) begin
                x[0] <= bus.sample_data;
                for (int k = 1; k < TAPS; k++) begin
                    x[k] <= x[k-1];
                end
            end
            if (state == LOAD) begin
                coeff[load_idx] <= bus.fir_coefficient;
            end
        end
    end

    fir_sample_counter #(
        .SAMPLE_COUNT (SAMPLE_COUNT)
    ) u_sample_counter (
        .clk           (clk),
        .n_reset       (n_reset),
        .cnt_up        (cnt_up),
        .clear         (coeff_clear),
        .one_k_samples (bus.one_k_samples)
    );

    assign bus.modwait = modwait_q;
    assign bus.fir_out = fir_out_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_fir_filter_param.sv
// Self-checking bench for fir_filter_param (DATA_W=16, TAPS=4, SAMPLE_COUNT=5).
// Expected results are queued when a request is driven and compared when
// modwait falls at the end of that request.
module tb_fir_filter_param;
    localparam int DATA_W       = 16;
    localparam int TAPS         = 4;
    localparam int SAMPLE_COUNT = 5;
    localparam int SAMPLE_BUSY  = TAPS + 1;
    localparam int KIND_SAMPLE  = 0;
    localparam int KIND_LOAD    = 1;
    localparam int KIND_BOTH    = 2;

    typedef struct {
        int          kind;
        logic [15:0] value;
        logic [15:0] exp_out;
        logic        exp_err;
        logic        exp_pulse;
        string       name;
    } vec_t;

    typedef struct {
        logic        is_sample;
        logic [15:0] exp_out;
        logic        exp_err;
        logic        exp_pulse;
        int          exp_busy;
        string       name;
    } exp_t;

    logic   clk = 1'b0;
    logic   n_reset = 1'b0;
    int     error_count = 0;
    int     check_count = 0;
    exp_t   sb_queue[$];
    vec_t   vec_table[$];

    fir_filter_param_if #(.DATA_W(DATA_W)) bus ();

    fir_filter_param #(
        .DATA_W       (DATA_W),
        .TAPS         (TAPS),
        .SAMPLE_COUNT (SAMPLE_COUNT)
    ) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic addVec(input int kind, input logic [15:0] value, input logic [15:0] exp_out,
                          input logic exp_err, input logic exp_pulse, input string name);
        vec_t v;
        v.kind      = kind;
        v.value     = value;
        v.exp_out   = exp_out;
        v.exp_err   = exp_err;
        v.exp_pulse = exp_pulse;
        v.name      = name;
        vec_table.push_back(v);
    endtask

    // Waits for the filter to be free, drives one request and queues its expectation.
    task automatic applyStimulus(input int kind, input logic [15:0] value, input logic [15:0] exp_out,
                                 input logic exp_err, input logic exp_pulse, input string name);
        exp_t e;
        int   waited = 0;
        @(negedge clk);
        while (bus.modwait && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (bus.modwait) begin
            checkOutput({name, "_idle_timeout"}, bus.modwait, 0);
            return;
        end
        e.is_sample = (kind != KIND_LOAD);
        e.exp_out   = exp_out;
        e.exp_err   = exp_err;
        e.exp_pulse = exp_pulse;
        e.exp_busy  = (kind == KIND_LOAD) ? 1 : SAMPLE_BUSY;
        e.name      = name;
        if (kind == KIND_LOAD) begin
            bus.load_coeff      = 1'b1;
            bus.fir_coefficient = value;
        end else if (kind == KIND_SAMPLE) begin
            bus.data_ready  = 1'b1;
            bus.sample_data = value;
        end else begin
            bus.data_ready      = 1'b1;
            bus.load_coeff      = 1'b1;
            bus.sample_data     = value;
            bus.fir_coefficient = 16'h7FFF;
        end
        sb_queue.push_back(e);
        @(negedge clk);
        bus.data_ready = 1'b0;
        bus.load_coeff = 1'b0;
    endtask

    // Pops an expectation at every falling edge of modwait and compares the result.
    task automatic monitorLoop();
        int   busy_count = 0;
        logic prev_modwait = 1'b0;
        logic check_pulse_low = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!n_reset) begin
                busy_count      = 0;
                prev_modwait    = 1'b0;
                check_pulse_low = 1'b0;
            end else begin
                if (check_pulse_low) begin
                    checkOutput("pulse_width", bus.one_k_samples, 0);
                    check_pulse_low = 1'b0;
                end
                if (bus.modwait) begin
                    busy_count++;
                end else if (prev_modwait) begin
                    if (sb_queue.size() == 0) begin
                        checkOutput("unexpected_done", sb_queue.size(), 1);
                    end else begin
                        e = sb_queue.pop_front();
                        checkOutput({e.name, "_busy"}, busy_count, e.exp_busy);
                        checkOutput({e.name, "_err"}, bus.err, e.exp_err);
                        checkOutput({e.name, "_pulse"}, bus.one_k_samples, e.exp_pulse);
                        if (e.is_sample) begin
                            checkOutput({e.name, "_out"}, bus.fir_out, e.exp_out);
                        end
                    end
                    busy_count      = 0;
                    check_pulse_low = 1'b1;
                end
                prev_modwait = bus.modwait;
            end
        end
    endtask

    initial begin
        int waited;
        bus.sample_data     = '0;
        bus.fir_coefficient = '0;
        bus.data_ready      = 1'b0;
        bus.load_coeff      = 1'b0;
        fork
            monitorLoop();
        join_none

        repeat (3) @(negedge clk);
        checkOutput("reset_modwait", bus.modwait, 0);
        checkOutput("reset_fir_out", bus.fir_out, 0);
        checkOutput("reset_pulse", bus.one_k_samples, 0);
        checkOutput("reset_err", bus.err, 0);
        n_reset = 1'b1;

        addVec(KIND_SAMPLE, 16'd1000, 16'd0, 1'b0, 1'b0, "cold_sample");
        for (int i = 0; i < 4; i++) addVec(KIND_LOAD, 16'h4000, 16'd0, 1'b0, 1'b0, "load_half");
        addVec(KIND_SAMPLE, 16'd1000, 16'd1000, 1'b0, 1'b0, "ramp1");
        addVec(KIND_SAMPLE, 16'd1000, 16'd1500, 1'b0, 1'b0, "ramp2");
        addVec(KIND_SAMPLE, 16'd1000, 16'd2000, 1'b0, 1'b0, "ramp3");
        addVec(KIND_SAMPLE, 16'd1000, 16'd2000, 1'b0, 1'b0, "ramp4");
        addVec(KIND_SAMPLE, 16'd0, 16'd1500, 1'b0, 1'b1, "drain1");
        addVec(KIND_SAMPLE, 16'd0, 16'd1000, 1'b0, 1'b0, "drain2");
        addVec(KIND_SAMPLE, 16'd0, 16'd500, 1'b0, 1'b0, "drain3");
        addVec(KIND_SAMPLE, 16'd0, 16'd0, 1'b0, 1'b0, "drain4");
        addVec(KIND_SAMPLE, 16'hFC18, 16'd500, 1'b0, 1'b0, "negative");
        for (int i = 0; i < 4; i++) addVec(KIND_LOAD, 16'h7FFF, 16'd0, 1'b0, 1'b0, "load_max");
        addVec(KIND_SAMPLE, 16'h7FFF, 16'h7C16, 1'b0, 1'b0, "sat1");
        addVec(KIND_SAMPLE, 16'h7FFF, 16'hFC14, 1'b0, 1'b0, "sat2");
        addVec(KIND_SAMPLE, 16'h7FFF, 16'hFFFF, 1'b1, 1'b0, "sat3");
        addVec(KIND_SAMPLE, 16'h7FFF, 16'hFFFF, 1'b1, 1'b0, "sat4");
        addVec(KIND_SAMPLE, 16'h7FFF, 16'hFFFF, 1'b1, 1'b1, "sat_sticky");
        for (int i = 0; i < 4; i++) addVec(KIND_LOAD, 16'h4000, 16'd0, 1'b0, 1'b0, "reload_clear");

        for (int i = 0; i < vec_table.size(); i++) begin
            applyStimulus(vec_table[i].kind, vec_table[i].value, vec_table[i].exp_out,
                          vec_table[i].exp_err, vec_table[i].exp_pulse, vec_table[i].name);
        end

        // Overrun two cycles after an accepted sample: flagged, sample discarded.
        applyStimulus(KIND_SAMPLE, 16'd0, 16'd49150, 1'b1, 1'b0, "overrun_victim");
        @(negedge clk);
        bus.sample_data = 16'd1234;
        bus.data_ready  = 1'b1;
        @(negedge clk);
        bus.data_ready = 1'b0;
        checkOutput("overrun_err_now", bus.err, 1);
        applyStimulus(KIND_SAMPLE, 16'd0, 16'h7FFF, 1'b1, 1'b0, "after_overrun");

        // Simultaneous requests: sample wins, load index stays at 0.
        applyStimulus(KIND_BOTH, 16'd0, 16'd16383, 1'b1, 1'b0, "both_req");
        applyStimulus(KIND_LOAD, 16'h4000, 16'd0, 1'b0, 1'b0, "load_idx0_clear");
        applyStimulus(KIND_SAMPLE, 16'd1000, 16'd500, 1'b0, 1'b0, "post_clear");

        // Block count: realign the counter, then 11 samples.
        for (int i = 0; i < 3; i++) applyStimulus(KIND_LOAD, 16'h4000, 16'd0, 1'b0, 1'b0, "block_load");
        applyStimulus(KIND_LOAD, 16'h4000, 16'd0, 1'b0, 1'b0, "block_load0");
        for (int i = 1; i <= 11; i++) begin
            applyStimulus(KIND_SAMPLE, 16'd0, (i <= 3) ? 16'd500 : 16'd0, 1'b0,
                          (i == 5 || i == 10), $sformatf("block%0d", i));
        end
        applyStimulus(KIND_SAMPLE, 16'd1000, 16'd500, 1'b0, 1'b0, "pre_reset");

        // Reset two cycles into MAC discards the partial result.
        waited = 0;
        @(negedge clk);
        while (bus.modwait && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("rst_idle_wait", bus.modwait, 0);
        bus.sample_data = 16'd2000;
        bus.data_ready  = 1'b1;
        @(negedge clk);
        bus.data_ready = 1'b0;
        @(posedge clk);
        #1;
        n_reset = 1'b0;
        sb_queue.delete();
        #1;
        checkOutput("rst_mid_modwait", bus.modwait, 0);
        checkOutput("rst_mid_fir_out", bus.fir_out, 0);
        checkOutput("rst_mid_err", bus.err, 0);
        checkOutput("rst_mid_pulse", bus.one_k_samples, 0);
        repeat (2) @(negedge clk);
        n_reset = 1'b1;

        applyStimulus(KIND_SAMPLE, 16'd1000, 16'd0, 1'b0, 1'b0, "cold_again");
        applyStimulus(KIND_LOAD, 16'h4000, 16'd0, 1'b0, 1'b0, "cold_load0");
        applyStimulus(KIND_SAMPLE, 16'd1000, 16'd500, 1'b0, 1'b0, "cold_result");

        waited = 0;
        while (sb_queue.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("drain_queue", sb_queue.size(), 0);

        $display("[TB] Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end
endmodule
